// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message schedule: word/round sizes and
// the sequencer state encoding.
package sha256_pkg;
  localparam int SHA256_WORD_W    = 32;
  localparam int SHA256_ROUNDS    = 64;
  localparam int SHA256_BLK_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    DRAIN  = 2'd3
  } sched_state_t;
endpackage

// File: rtl/sha256_sigma0.sv
// SHA-256 small sigma0: rotr7 ^ rotr18 ^ shr3, purely combinational.
module sha256_sigma0
  import sha256_pkg::*;
(
  input  logic [SHA256_WORD_W-1:0] i_x,
  output logic [SHA256_WORD_W-1:0] o_y
);
  assign o_y = {i_x[6:0], i_x[31:7]} ^ {i_x[17:0], i_x[31:18]} ^ (i_x >> 3);
endmodule

// File: rtl/sha256_sigma1.sv
// SHA-256 small sigma1: rotr17 ^ rotr19 ^ shr10, same form as sigma0.
module sha256_sigma1
  import sha256_pkg::*;
(
  input  logic [SHA256_WORD_W-1:0] i_x,
  output logic [SHA256_WORD_W-1:0] o_y
);
  assign o_y = {i_x[16:0], i_x[31:17]} ^ {i_x[18:0], i_x[31:19]} ^ (i_x >> 10);
endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads M0..M15, then expands W16..W63 from a
// 16-entry circular buffer, streaming W[t] out over a valid/ready port.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS,
  parameter int IDX_W  = $clog2(ROUNDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [SHA256_WORD_W-1:0] blk_word,
  input  logic                     blk_word_valid,
  output logic                     blk_word_ready,
  output logic [SHA256_WORD_W-1:0] w_out,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic [IDX_W-1:0]         w_idx,
  output logic                     busy,
  output logic                     done,
  output sched_state_t             dbg_state
);
  // Both ports are valid/ready: a transfer happens at a rising edge where
  // valid && ready; the producer holds data stable while valid && !ready.
  localparam logic [IDX_W-1:0] LOAD_LAST = IDX_W'(SHA256_BLK_WORDS - 1);
  localparam logic [IDX_W-1:0] EXP_LAST  = IDX_W'(ROUNDS - 1);

  sched_state_t             r_state;
  sched_state_t             w_next_state;
  logic [IDX_W-1:0]         r_t;
  logic [SHA256_WORD_W-1:0] r_buf [SHA256_BLK_WORDS];
  logic [SHA256_WORD_W-1:0] r_w_out;
  logic                     r_w_valid;
  logic [IDX_W-1:0]         r_w_idx;
  logic                     r_done;

  logic                     w_oreg_free;
  logic                     w_load_acc;
  logic                     w_exp_gen;
  logic                     w_drain_acc;
  logic [3:0]               w_p0, w_p1, w_p9, w_p14;
  logic [SHA256_WORD_W-1:0] w_s0, w_s1, w_exp_word, w_new_word;

  assign w_oreg_free = !r_w_valid || w_ready;
  assign w_load_acc  = (r_state == LOAD) && blk_word_valid && w_oreg_free;
  assign w_exp_gen   = (r_state == EXPAND) && w_oreg_free;
  assign w_drain_acc = (r_state == DRAIN) && r_w_valid && w_ready;

  // Buffer taps wrap at 16 entries: W[t-2], W[t-7], W[t-15], W[t-16].
  assign w_p0  = r_t[3:0];
  assign w_p1  = r_t[3:0] + 4'd1;
  assign w_p9  = r_t[3:0] + 4'd9;
  assign w_p14 = r_t[3:0] + 4'd14;

  sha256_sigma0 u_sigma0 (.i_x(r_buf[w_p1]),  .o_y(w_s0));
  sha256_sigma1 u_sigma1 (.i_x(r_buf[w_p14]), .o_y(w_s1));

  assign w_exp_word = w_s1 + r_buf[w_p9] + w_s0 + r_buf[w_p0];
  assign w_new_word = w_load_acc ? blk_word : w_exp_word;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = LOAD;
      LOAD:    if (w_load_acc && (r_t == LOAD_LAST)) w_next_state = EXPAND;
      EXPAND:  if (w_exp_gen && (r_t == EXP_LAST)) w_next_state = DRAIN;
      DRAIN:   if (w_drain_acc) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    blk_word_ready = (r_state == LOAD) && w_oreg_free;
    busy           = (r_state != IDLE);
    dbg_state      = r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_t       <= '0;
      r_w_out   <= '0;
      r_w_valid <= 1'b0;
      r_w_idx   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_drain_acc;
      if ((r_state == IDLE) && start) r_t <= '0;
      // A new word may overwrite the one being consumed in the same cycle.
      if (w_load_acc || w_exp_gen) begin
        r_w_out   <= w_new_word;
        r_w_idx   <= r_t;
        r_w_valid <= 1'b1;
        r_t       <= r_t + 1'b1;
      end else if (w_ready) begin
        r_w_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_acc || w_exp_gen) r_buf[w_p0] <= w_new_word;
  end

  assign w_out   = r_w_out;
  assign w_valid = r_w_valid;
  assign w_idx   = r_w_idx;
  assign done    = r_done;
endmodule
